// File: rtl/mm_result_writeback_pkg.sv
// Shared definitions for the matrix-multiplication result write-back stage.
// Holds the default result element width, default result matrix shape and
// the write-back FSM state encoding.
package mm_result_writeback_pkg;

  localparam int RESULT_DWIDTH = 16;
  localparam int DEFAULT_ROWS  = 4;
  localparam int DEFAULT_COLS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/mm_result_writeback_if.sv
// Result-memory write port (valid/ready).
//   mem_req   : write request, driven by the master
//   mem_addr  : write word address, driven by the master
//   mem_wdata : write data, driven by the master
//   mem_ready : memory accepts, driven by the slave
// A transfer happens on a clock edge where mem_req && mem_ready.
interface mm_result_writeback_if
  import mm_result_writeback_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = RESULT_DWIDTH
);

  logic              mem_req;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );

endinterface

// File: rtl/mm_result_writeback_fifo.sv
// mm_result_fifo: parameterised synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush (pointers back to empty)
//   push, din  : write din at the tail; caller must not push when full
//                unless popping in the same cycle
//   pop        : drop the head; caller must not pop when empty
//   dout       : current head entry
//   full/empty : occupancy flags
// DEPTH must be a power of two >= 2.
module mm_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; consumers only look at dout while non-empty.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[PW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  // Same slot but different wrap bit means the writer is a full lap ahead.
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/mm_result_writeback.sv
// mm_result_writeback: buffers finished result elements from the end adder
// and writes them row-major into result memory, one job of ROWS*COLS
// elements at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : job start pulse, honoured only when idle
//   base_addr  : result base word address, latched on start
//   sum_in     : result element, qualified by valid_in (no backpressure)
//   wr         : result-memory write port (master side)
//   busy       : job in progress
//   done       : one-cycle pulse at job end
//   err        : sticky overflow / stray-input flag, cleared on start
module mm_result_writeback
  import mm_result_writeback_pkg::*;
#(
  parameter int DWIDTH     = RESULT_DWIDTH,
  parameter int ROWS       = DEFAULT_ROWS,
  parameter int COLS       = DEFAULT_COLS,
  parameter int AWIDTH     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AWIDTH-1:0]     base_addr,
  input  logic [DWIDTH-1:0]     sum_in,
  input  logic                  valid_in,
  mm_result_writeback_if.master wr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int            NUM_ELEMS = ROWS * COLS;
  localparam int            CW        = $clog2(NUM_ELEMS + 1);
  localparam logic [CW-1:0] JOB_CNT   = CW'(NUM_ELEMS);
  localparam logic [CW:0]   JOB_TOTAL = (CW+1)'(NUM_ELEMS);

  wb_state_e         state_q, state_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [CW-1:0]     in_cnt_q, in_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              err_q, err_d;

  logic              fifo_push, fifo_pop, fifo_clear;
  logic              fifo_full, fifo_empty;
  logic [DWIDTH-1:0] fifo_dout;
  logic              mem_req;

  mm_result_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DWIDTH (DWIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sum_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mem_req  = (state_q == ST_RUN) && !fifo_empty;
  assign fifo_pop = mem_req && wr.mem_ready;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q;
    fifo_push  = 1'b0;
    fifo_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          drop_cnt_d = '0;
          err_d      = 1'b0;
          fifo_clear = 1'b1;
          state_d    = ST_RUN;
        end else if (valid_in) begin
          err_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (valid_in) begin
          if (in_cnt_q < JOB_CNT) begin
            in_cnt_d = in_cnt_q + CW'(1);
            // A full FIFO still takes the element if the head leaves this cycle.
            if (!fifo_full || fifo_pop) begin
              fifo_push = 1'b1;
            end else begin
              drop_cnt_d = drop_cnt_q + CW'(1);
              err_d      = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        if (fifo_pop) out_cnt_d = out_cnt_q + CW'(1);
        // Dropped elements count toward completion so a lossy job still ends.
        if (({1'b0, out_cnt_d} + {1'b0, drop_cnt_d}) == JOB_TOTAL) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (valid_in) err_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  // Address and data are forced to zero whenever no write is pending.
  assign wr.mem_req   = mem_req;
  assign wr.mem_addr  = mem_req ? (base_q + AWIDTH'(out_cnt_q)) : '0;
  assign wr.mem_wdata = mem_req ? fifo_dout : '0;

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

endmodule
